// File: rtl/decode_writeback_pkg.sv
// Shared definitions for the Y86-64 decode/writeback stage.
//   - instruction codes (icode), register ids, status codes
//   - e_reg_t: contents of the execute pipeline register
//   - E_BUBBLE: value loaded on a bubble or held during reset
//   - fwd_select: forwarding priority mux shared by both operand paths
package decode_writeback_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  localparam logic [3:0] STAT_AOK = 4'h8;
  localparam logic [3:0] STAT_HLT = 4'h4;
  localparam logic [3:0] STAT_ADR = 4'h2;
  localparam logic [3:0] STAT_INS = 4'h1;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [3:0]  stat;
    logic [63:0] val_c;
    logic [63:0] val_a;
    logic [63:0] val_b;
  } e_reg_t;

  localparam e_reg_t E_BUBBLE = '{
    icode: I_NOP, ifun: 4'h0,
    dst_e: RNONE, dst_m: RNONE, src_a: RNONE, src_b: RNONE,
    stat:  STAT_AOK,
    val_c: 64'h0, val_a: 64'h0, val_b: 64'h0
  };

  // Youngest producer wins: execute, then memory (load result before ALU
  // result), then writeback (load result before ALU result). RNONE never
  // matches, so a "none" source falls through to the file read (which is 0).
  function automatic logic [63:0] fwd_select(
    input logic [3:0]  src,
    input logic [3:0]  e_dst_e, input logic [63:0] e_val_e,
    input logic [3:0]  m_dst_m, input logic [63:0] m_val_m,
    input logic [3:0]  m_dst_e, input logic [63:0] m_val_e,
    input logic [3:0]  w_dst_m, input logic [63:0] w_val_m,
    input logic [3:0]  w_dst_e, input logic [63:0] w_val_e,
    input logic [63:0] rf_val
  );
    logic [63:0] r;
    r = rf_val;
    if (src != RNONE) begin
      if      (src == e_dst_e) r = e_val_e;
      else if (src == m_dst_m) r = m_val_m;
      else if (src == m_dst_e) r = m_val_e;
      else if (src == w_dst_m) r = w_val_m;
      else if (src == w_dst_e) r = w_val_e;
    end
    return r;
  endfunction

endpackage

// File: rtl/decode_writeback_regfile.sv
// Register file: 15 x 64-bit registers (ids 0-14), id F = "none".
//   rd_a_id/rd_a_val, rd_b_id/rd_b_val : combinational read ports (F reads 0)
//   wr_e_id/wr_e_val, wr_m_id/wr_m_val : write ports, committed on rising clk
//   rst                                 : asynchronous clear of all registers
// Reads see stored contents only; a write in the same cycle is not bypassed
// here (the decode stage forwards it instead).
module regfile
  import decode_writeback_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rd_a_id,
  output logic [63:0] rd_a_val,
  input  logic [3:0]  rd_b_id,
  output logic [63:0] rd_b_val,
  input  logic [3:0]  wr_e_id,
  input  logic [63:0] wr_e_val,
  input  logic [3:0]  wr_m_id,
  input  logic [63:0] wr_m_val
);

  logic [63:0] regs_q [15];
  logic [63:0] regs_d [15];

  always_comb begin
    regs_d = regs_q;
    if (wr_e_id != RNONE) regs_d[wr_e_id] = wr_e_val;
    // Applied second so the load result wins when both ports name one register.
    if (wr_m_id != RNONE) regs_d[wr_m_id] = wr_m_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '{default: 64'h0};
    else     regs_q <= regs_d;
  end

  assign rd_a_val = (rd_a_id == RNONE) ? 64'h0 : regs_q[rd_a_id];
  assign rd_b_val = (rd_b_id == RNONE) ? 64'h0 : regs_q[rd_b_id];

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode + writeback stage.
//   D_*            : decode pipeline register from fetch
//   e_/M_/W_ dst,val: forwarding sources; W_* also write the register file
//   E_bubble       : load a bubble into the execute register
//   E_*            : execute pipeline register (registered outputs)
//   d_srcA/d_srcB  : combinational source ids for hazard control
module decode_writeback
  import decode_writeback_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic [3:0]  D_stat,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] m_valM,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] M_valE,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  input  logic        E_bubble,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB,
  output logic [3:0]  E_stat,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB
);

  logic [3:0]  d_dst_e, d_dst_m;
  logic [63:0] rf_val_a, rf_val_b;
  logic [63:0] d_val_a, d_val_b;
  e_reg_t      e_d, e_q;

  // Register ids per instruction; invalid icodes fall to RNONE everywhere.
  always_comb begin
    d_srcA  = RNONE;
    d_srcB  = RNONE;
    d_dst_e = RNONE;
    d_dst_m = RNONE;
    unique case (D_icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = D_rA;
      I_RET, I_POPQ:                      d_srcA = RSP;
      default: ;
    endcase
    unique case (D_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:         d_srcB = D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:    d_srcB = RSP;
      default: ;
    endcase
    unique case (D_icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:         d_dst_e = D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:    d_dst_e = RSP;
      default: ;
    endcase
    unique case (D_icode)
      I_MRMOVQ, I_POPQ:                  d_dst_m = D_rA;
      default: ;
    endcase
  end

  regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd_a_id  (d_srcA),
    .rd_a_val (rf_val_a),
    .rd_b_id  (d_srcB),
    .rd_b_val (rf_val_b),
    .wr_e_id  (W_dstE),
    .wr_e_val (W_valE),
    .wr_m_id  (W_dstM),
    .wr_m_val (W_valM)
  );

  // valA doubles as the return/next PC carrier for jumps and calls, so
  // D_valP overrides forwarding for those.
  always_comb begin
    if (D_icode == I_JXX || D_icode == I_CALL)
      d_val_a = D_valP;
    else
      d_val_a = fwd_select(d_srcA, e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
                           W_dstM, W_valM, W_dstE, W_valE, rf_val_a);
    d_val_b = fwd_select(d_srcB, e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
                         W_dstM, W_valM, W_dstE, W_valE, rf_val_b);
  end

  always_comb begin
    e_d = E_BUBBLE;
    if (!E_bubble) begin
      e_d.icode = D_icode;
      e_d.ifun  = D_ifun;
      e_d.dst_e = d_dst_e;
      e_d.dst_m = d_dst_m;
      e_d.src_a = d_srcA;
      e_d.src_b = d_srcB;
      e_d.stat  = D_stat;
      e_d.val_c = D_valC;
      e_d.val_a = d_val_a;
      e_d.val_b = d_val_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) e_q <= E_BUBBLE;
    else     e_q <= e_d;
  end

  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_dstE  = e_q.dst_e;
  assign E_dstM  = e_q.dst_m;
  assign E_srcA  = e_q.src_a;
  assign E_srcB  = e_q.src_b;
  assign E_stat  = e_q.stat;
  assign E_valC  = e_q.val_c;
  assign E_valA  = e_q.val_a;
  assign E_valB  = e_q.val_b;

endmodule
